ysyx_23060201_pc_gen: RTL and testbench
=======================================

// Module: ysyx_23060201_pc_gen
// PURPOSE
//  Program-counter generator feeding the IFU pc input. Holds the architectural PC, offers it
//  with a valid/ready handshake, advances by 4 on each accepted fetch, and applies
//  trap/branch redirects from EXU/CSR. Also counts retired fetches and parks on a halt request.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC value loaded on reset (start of pmem)
//  CNT_W     32             width of fetch counter fetch_cnt
// PORTS
//  clk              in   1      system clock, all state on rising edge
//  rst              in   1      asynchronous, active-high reset
//  pc_ready         in   1      IFU accepts pc this cycle
//  redirect_valid   in   1      branch/jump taken; redirect_target is next PC
//  redirect_target  in   32     branch/jump target
//  trap_valid       in   1      exception/mret redirect
//  trap_target      in   32     mtvec / mepc value
//  halt_req         in   1      ebreak seen; stop fetching
//  pc_valid         out  1      pc holds a fetch request
//  pc               out  32     current fetch address (to IFU)
//  halted           out  1      block is in HALTED
//  fetch_cnt        out  CNT_W  number of accepted fetches (fire count)
//  misalign         out  1      1-cycle pulse: rejected misaligned redirect (macro only)
//  misalign_addr    out  32     offending target, held until next misalign (macro only)
// BEHAVIOUR
//  - Reset (async): state=BOOT, pc=RESET_PC, pc_valid=0, halted=0, fetch_cnt=0, misalign=0,
//    misalign_addr=0. Release is sampled on the next clk edge.
//  - States: BOOT -> RUN after exactly one clk edge (gives pmem one idle cycle);
//    RUN -> HALTED when halt_req=1 at a clk edge; HALTED is terminal until rst.
//  - pc_valid = (state==RUN); combinational from state only, never from pc_ready.
//  - fire = pc_valid & pc_ready. fetch_cnt += 1 on fire, wraps mod 2^CNT_W.
//  - Next-PC priority at each edge in RUN: halt_req (pc held) > trap_valid (pc<=trap_target)
//    > redirect_valid (pc<=redirect_target) > fire (pc<=pc+4) > hold.
//  - Redirects take effect regardless of fire; a fire in the same cycle still counts
//    in fetch_cnt but its pc+4 is discarded.
//  - pc+4 is 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
//  - trap_valid/redirect_valid/halt_req ignored in BOOT and HALTED; pc frozen in HALTED.
//  - trap_target taken verbatim (CSR guarantees alignment).
//  - Redirect latency: target visible on pc in the cycle after the request edge.
// CONFIGURATION
//  PCGEN_MISALIGN_CHECK_EN defined:
//   - redirect (not trap) with redirect_target[1:0]!=0 is rejected: pc held, misalign=1 for
//     one cycle, misalign_addr<=redirect_target. trap_valid in same cycle still wins.
//  Not defined:
//   - redirect_target[1:0] forced to 2'b00 before load; misalign and misalign_addr tied 0.
// TESTING
//  1 rst=1 then release, pc_ready=1 -> cycle1 pc_valid=0; then pc=8000_0000,8000_0004,
//    8000_0008...; fetch_cnt=3 after 3 fires.
//  2 pc_ready=0 for 5 cycles -> pc held, pc_valid=1, fetch_cnt unchanged.
//  3 at pc=8000_0010 assert redirect_valid+trap_valid, targets 8000_0100/8000_0200 ->
//    next pc=8000_0200.
//  4 redirect_target=8000_0102 -> macro on: pc held, misalign pulse, misalign_addr=8000_0102;
//    macro off: pc=8000_0100.
//  5 halt_req with redirect_valid -> halted=1, pc_valid=0, pc unchanged; later redirects ignored.
//  6 assert rst mid-RUN between edges -> outputs return to reset values immediately.

Source files
------------

// File: rtl/ysyx_23060201_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060201_pc_gen
// Brief    : Program-counter generator for the IFU. Holds the architectural
//            PC, offers it with a valid/ready handshake, steps by 4 on each
//            accepted fetch, applies trap/branch redirects, counts accepted
//            fetches and parks permanently on a halt request.
// Config   : PCGEN_MISALIGN_CHECK_EN - when defined, misaligned branch
//            targets are rejected and reported; otherwise their low two bits
//            are cleared before loading.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060201_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_ready_i,
    input  logic             redirect_valid_i,
    input  logic [31:0]      redirect_target_i,
    input  logic             trap_valid_i,
    input  logic [31:0]      trap_target_i,
    input  logic             halt_req_i,
    output logic             pc_valid_o,
    output logic [31:0]      pc_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic             misalign_o,
    output logic [31:0]      misalign_addr_o
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;
    logic             redirect_bad;
    logic [31:0]      redirect_pc;

`ifdef PCGEN_MISALIGN_CHECK_EN
    logic             mis_q, mis_d;
    logic [31:0]      maddr_q, maddr_d;

    assign redirect_bad    = (redirect_target_i[1:0] != 2'b00);
    assign redirect_pc     = redirect_target_i;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = maddr_q;
`else
    // Low target bits are deliberately discarded in this build.
    logic             w_unused_tgt_lsb;

    assign w_unused_tgt_lsb = ^redirect_target_i[1:0];
    assign redirect_bad     = 1'b0;
    assign redirect_pc      = {redirect_target_i[31:2], 2'b00};
    assign misalign_o       = 1'b0;
    assign misalign_addr_o  = 32'h0;
`endif

    // Outputs decode the state register only, never the IFU ready.
    assign pc_valid_o  = (state_q == ST_RUN);
    assign halted_o    = (state_q == ST_HALTED);
    assign pc_o        = pc_q;
    assign fetch_cnt_o = cnt_q;
    assign fire        = pc_valid_o & pc_ready_i;

    // Next-state: halt > trap > redirect > sequential step > hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PCGEN_MISALIGN_CHECK_EN
        mis_d   = 1'b0;
        maddr_d = maddr_q;
`endif
        // An accepted fetch always counts, even if its pc+4 is overridden.
        if (fire) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req_i) begin
                    state_d = ST_HALTED;
                end else if (trap_valid_i) begin
                    pc_d = trap_target_i;
                end else if (redirect_valid_i) begin
                    if (redirect_bad) begin
`ifdef PCGEN_MISALIGN_CHECK_EN
                        mis_d   = 1'b1;
                        maddr_d = redirect_target_i;
`endif
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (fire) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
`ifdef PCGEN_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
            maddr_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PCGEN_MISALIGN_CHECK_EN
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060201_pc_gen
// Brief    : Self-checking bench for the PC generator: directed scenarios and
//            random traffic compared against a behavioural model.
// Config   : honours PCGEN_MISALIGN_CHECK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060201_pc_gen;

`ifdef PCGEN_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_ready_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = 32'h0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_target_i = 32'h0;
    logic        halt_req_i = 1'b0;
    logic        pc_valid_o;
    logic [31:0] pc_o;
    logic        halted_o;
    logic [31:0] fetch_cnt_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: 0 = boot, 1 = running, 2 = halted
    int          m_state;
    logic [31:0] m_pc, m_cnt, m_maddr;
    logic        m_mis;

    ysyx_23060201_pc_gen #(
        .RESET_PC (32'h8000_0000),
        .CNT_W    (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_ready_i        (pc_ready_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .trap_valid_i      (trap_valid_i),
        .trap_target_i     (trap_target_i),
        .halt_req_i        (halt_req_i),
        .pc_valid_o        (pc_valid_o),
        .pc_o              (pc_o),
        .halted_o          (halted_o),
        .fetch_cnt_o       (fetch_cnt_o),
        .misalign_o        (misalign_o),
        .misalign_addr_o   (misalign_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h8000_0000;
        m_cnt   = 0;
        m_mis   = 1'b0;
        m_maddr = 32'h0;
    endtask

    // One clock edge of the architectural rules, using the inputs present now.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        m_mis = 1'b0;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (pc_ready_i) m_cnt = m_cnt + 1;
            if (halt_req_i) m_state = 2;
            else if (trap_valid_i) m_pc = trap_target_i;
            else if (redirect_valid_i) begin
                if (CHK_EN && (redirect_target_i % 4 != 0)) begin
                    m_mis   = 1'b1;
                    m_maddr = redirect_target_i;
                end else begin
                    m_pc = redirect_target_i - (redirect_target_i % 4);
                end
            end else if (pc_ready_i) m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".pc_valid"}, {31'd0, pc_valid_o}, {31'd0, m_state == 1});
        chk({ph, ".pc"}, pc_o, m_pc);
        chk({ph, ".halted"}, {31'd0, halted_o}, {31'd0, m_state == 2});
        chk({ph, ".fetch_cnt"}, fetch_cnt_o, m_cnt);
        chk({ph, ".misalign"}, {31'd0, misalign_o}, {31'd0, m_mis});
        chk({ph, ".misalign_addr"}, misalign_addr_o, m_maddr);
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic idle_inputs();
        redirect_valid_i = 1'b0;
        trap_valid_i     = 1'b0;
        halt_req_i       = 1'b0;
    endtask

    task automatic rand_inputs(input bit allow_halt);
        pc_ready_i        = ($urandom_range(0, 3) != 0);
        redirect_valid_i  = ($urandom_range(0, 3) == 0);
        redirect_target_i = $urandom;
        if ($urandom_range(0, 1) == 0) redirect_target_i[1:0] = 2'b00;
        trap_valid_i      = ($urandom_range(0, 7) == 0);
        trap_target_i     = $urandom & 32'hFFFF_FFFC;
        halt_req_i        = allow_halt && ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        model_reset();
        // Reset and release
        #1 rst = 1'b1;
        #1 check_all("reset");
        tick("reset_hold");
        #2 rst = 1'b0;
        pc_ready_i = 1'b1;
        chk("boot.pc_valid_low", {31'd0, pc_valid_o}, 32'd0);
        tick("boot");
        chk("run.first_pc", pc_o, 32'h8000_0000);
        for (int i = 0; i < 3; i++) tick("seq");
        chk("seq.pc_after3", pc_o, 32'h8000_000C);
        chk("seq.cnt3", fetch_cnt_o, 32'd3);

        // IFU stalls
        pc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) tick("stall");
        chk("stall.pc", pc_o, 32'h8000_000C);
        chk("stall.cnt", fetch_cnt_o, 32'd3);

        // Trap beats redirect
        pc_ready_i = 1'b1;
        tick("step");
        chk("step.pc", pc_o, 32'h8000_0010);
        redirect_valid_i  = 1'b1; redirect_target_i = 32'h8000_0100;
        trap_valid_i      = 1'b1; trap_target_i     = 32'h8000_0200;
        tick("trap_vs_redir");
        chk("trap_vs_redir.pc", pc_o, 32'h8000_0200);
        chk("trap_vs_redir.cnt", fetch_cnt_o, 32'd5);

        // Misaligned redirect
        trap_valid_i = 1'b0;
        redirect_target_i = 32'h8000_0102;
        tick("misalign");
        if (CHK_EN) begin
            chk("misalign.pc_held", pc_o, 32'h8000_0200);
            chk("misalign.pulse", {31'd0, misalign_o}, 32'd1);
            chk("misalign.addr", misalign_addr_o, 32'h8000_0102);
        end else begin
            chk("misalign.pc_forced", pc_o, 32'h8000_0100);
            chk("misalign.tied", {31'd0, misalign_o}, 32'd0);
        end
        idle_inputs();
        tick("misalign_after");
        chk("misalign.pulse_end", {31'd0, misalign_o}, 32'd0);

        // PC wraps at the top of the address space
        trap_valid_i = 1'b1; trap_target_i = 32'hFFFF_FFFC;
        tick("wrap_setup");
        trap_valid_i = 1'b0;
        tick("wrap");
        chk("wrap.pc", pc_o, 32'h0000_0000);

        // Random traffic without halts
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b0);
            tick("rand");
        end

        // Halt wins over redirect, then everything is ignored
        idle_inputs();
        tick("pre_halt");
        begin
            logic [31:0] pc_at_halt;
            pc_at_halt = pc_o;
            halt_req_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h1234_5678;
            tick("halt");
            chk("halt.halted", {31'd0, halted_o}, 32'd1);
            chk("halt.pc_valid", {31'd0, pc_valid_o}, 32'd0);
            chk("halt.pc", pc_o, pc_at_halt);
            for (int i = 0; i < 20; i++) begin
                rand_inputs(1'b1);
                tick("halted_rand");
            end
            chk("halted.pc_frozen", pc_o, pc_at_halt);
        end

        // Async reset mid-run
        idle_inputs();
        rst = 1'b1;
        tick("rst2");
        rst = 1'b0;
        pc_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick("rerun");
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst.pc", pc_o, 32'h8000_0000);
        chk("async_rst.cnt", fetch_cnt_o, 32'd0);
        #1 rst = 1'b0;
        tick("post_rst_boot");

        // Random traffic including halts
        for (int i = 0; i < 200; i++) begin
            rand_inputs(1'b1);
            tick("rand2");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
